// File: rtl/leg_alu_mc.sv
// leg_alu_mc: multi-cycle LEG ALU with registered NZCV flags and valid/ready on both sides.
// Define LEG_ALU_MULDIV_EN to build the iterative MUL/DIV/MOD unit; otherwise opcodes 10-12 act as reserved.
module leg_alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DONE = 2'd2;
`ifdef LEG_ALU_MULDIV_EN
    localparam logic [1:0] S_BUSY = 2'd1;
`endif

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_ASR  = 4'd8;
    localparam logic [3:0] OP_ROL  = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd14;
    localparam logic [3:0] OP_NAND = 4'd15;
`ifdef LEG_ALU_MULDIV_EN
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIV  = 4'd11;
    localparam logic [3:0] OP_MOD  = 4'd12;
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             accept;

    assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign flags     = flags_q;

    // Single-cycle datapath, evaluated on the live inputs at the accepting edge.
    logic [SW-1:0]      amt;
    logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w, asr_w;
    logic [2*WIDTH-1:0] rol_w;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;
    logic [3:0]         alu_flags;

    assign amt = b[SW-1:0];

    // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        add_w   = {1'b0, a} + {1'b0, b};
        sub_w   = {1'b0, a} - {1'b0, b};
        shl_w   = {1'b0, a} << amt;
        shr_w   = {a, 1'b0} >> amt;
        asr_w   = $signed({a, 1'b0}) >>> amt;
        rol_w   = {a, a} << amt;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = ~sub_w[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NOT:  alu_res = ~a;
            OP_XOR:  alu_res = a ^ b;
            // The extra bit beside the operand catches the last bit shifted out (0 for amount 0).
            OP_SHL: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_w[WIDTH:1];
                alu_c   = shr_w[0];
            end
            OP_ASR: begin
                alu_res = asr_w[WIDTH:1];
                alu_c   = asr_w[0];
            end
            OP_ROL:  alu_res = rol_w[2*WIDTH-1:WIDTH];
            OP_NOR:  alu_res = ~(a | b);
            OP_NAND: alu_res = ~(a & b);
            default: alu_res = '0;
        endcase
        alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
    end

`ifdef LEG_ALU_MULDIV_EN
    // acc_q is {high, low}: product/multiplier for MUL, remainder/quotient for DIV and MOD.
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic               is_md;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_sh;
    logic [WIDTH:0]     rem_sh, trial;
    logic               div_ge;
    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH-1:0]   md_res;
    logic               md_c;
    logic [3:0]         md_flags;

    assign is_md = (opcode == OP_MUL) || (opcode == OP_DIV) || (opcode == OP_MOD);
    assign busy  = (state_q == S_BUSY);

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_sh   = {mul_sum, acc_q[WIDTH-1:0]};
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        trial    = rem_sh - {1'b0, opb_q};
        div_ge   = ~trial[WIDTH];
        step_acc = {div_ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
        if (op_q == OP_MUL) begin
            step_acc = mul_sh[2*WIDTH:1];
        end
        md_res = step_acc[WIDTH-1:0];
        md_c   = (opb_q == '0);
        if (op_q == OP_MUL) begin
            md_c = |step_acc[2*WIDTH-1:WIDTH];
        end else if (op_q == OP_MOD) begin
            md_res = step_acc[2*WIDTH-1:WIDTH];
        end
        md_flags = {md_res[WIDTH-1], (md_res == '0), md_c, 1'b0};
    end
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
`ifdef LEG_ALU_MULDIV_EN
        op_d     = op_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (accept && is_md) begin
            state_d = S_BUSY;
            op_d    = opcode;
            opb_d   = b;
            acc_d   = {{WIDTH{1'b0}}, a};
            cnt_d   = SW'(WIDTH - 1);
        end else
`endif
        if (accept) begin
            state_d  = S_DONE;
            result_d = alu_res;
            flags_d  = alu_flags;
        end else if ((state_q == S_DONE) && out_ready) begin
            state_d = S_IDLE;
        end
`ifdef LEG_ALU_MULDIV_EN
        if (state_q == S_BUSY) begin
            acc_d = step_acc;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                state_d  = S_DONE;
                result_d = md_res;
                flags_d  = md_flags;
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
`ifdef LEG_ALU_MULDIV_EN
            op_q     <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
`ifdef LEG_ALU_MULDIV_EN
            op_q     <= op_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_leg_alu_mc.sv
// Directed self-checking bench for leg_alu_mc (WIDTH=8); expectations follow LEG_ALU_MULDIV_EN.
module tb_leg_alu_mc;

    localparam int WIDTH = 8;
`ifdef LEG_ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    leg_alu_mc #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb);
        in_valid = 1'b1;
        opcode   = op;
        a        = va;
        b        = vb;
    endtask

    // Back-to-back single-cycle op with out_ready held high.
    task automatic bb(input string tag, input logic [3:0] op, input logic [7:0] va,
                      input logic [7:0] vb, input logic [7:0] er, input logic [3:0] ef);
        drive(op, va, vb);
        out_ready = 1'b1;
        #1 check({tag, ".in_ready"}, in_ready, 1);
        tick();
        check({tag, ".out_valid"}, out_valid, 1);
        check({tag, ".result"}, result, er);
        check({tag, ".flags"}, flags, ef);
    endtask

    // MUL/DIV/MOD: latency, busy length, ignored requests while busy, operand capture.
    task automatic md(input string tag, input logic [3:0] op, input logic [7:0] va,
                      input logic [7:0] vb, input logic [7:0] er, input logic [3:0] ef);
        int lat;
        int busy_cnt;
        drive(op, va, vb);
        out_ready = 1'b0;
        tick();
        drive(4'd0, 8'h11, 8'h22);
        lat      = 1;
        busy_cnt = busy ? 1 : 0;
        check({tag, ".in_ready_first"}, in_ready, 0);
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
            if (busy) busy_cnt++;
        end
        check({tag, ".latency"}, lat, MD ? WIDTH + 1 : 1);
        check({tag, ".busy_cycles"}, busy_cnt, MD ? WIDTH : 0);
        check({tag, ".result"}, result, MD ? er : 8'h00);
        check({tag, ".flags"}, flags, MD ? ef : 4'b0100);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check({tag, ".idle"}, out_valid, 0);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        opcode    = 4'd0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst.out_valid", out_valid, 0);
        check("rst.result", result, 0);
        check("rst.flags", flags, 0);
        check("rst.busy", busy, 0);
        rst = 1'b1;
        #1 check("rst.in_ready", in_ready, 1);

        // ADD overflow into the sign bit.
        drive(4'd0, 8'h7F, 8'h01);
        tick();
        in_valid = 1'b0;
        check("add.out_valid", out_valid, 1);
        check("add.result", result, 8'h80);
        check("add.flags", flags, 4'b1001);
        out_ready = 1'b1;
        tick();
        check("add.idle", out_valid, 0);

        // Back-to-back stream through DONE.
        bb("sub_eq",  4'd1,  8'h05, 8'h05, 8'h00, 4'b0110);
        bb("shl",     4'd6,  8'h81, 8'h09, 8'h02, 4'b0010);
        bb("sub_lt",  4'd1,  8'h03, 8'h05, 8'hFE, 4'b1000);
        bb("add_c",   4'd0,  8'hFF, 8'h01, 8'h00, 4'b0110);
        bb("asr",     4'd8,  8'h81, 8'h03, 8'hF0, 4'b1000);
        bb("shr0",    4'd7,  8'h81, 8'h08, 8'h81, 4'b1000);
        bb("shr2",    4'd7,  8'h06, 8'h02, 8'h01, 4'b0010);
        bb("rol",     4'd9,  8'h81, 8'h0C, 8'h18, 4'b0000);
        bb("nand",    4'd15, 8'hF0, 8'h3C, 8'hCF, 4'b1000);
        bb("nor",     4'd14, 8'hF0, 8'h0C, 8'h03, 4'b0000);
        bb("rsv",     4'd13, 8'h12, 8'h34, 8'h00, 4'b0100);
        in_valid = 1'b0;
        tick();
        check("bb.idle", out_valid, 0);

        md("mul",     4'd10, 8'h10, 8'h20, 8'h00, 4'b0110);
        md("div0",    4'd11, 8'h2A, 8'h00, 8'hFF, 4'b1010);
        md("mod",     4'd12, 8'h2A, 8'h05, 8'h02, 4'b0000);
        md("mul_ovf", 4'd10, 8'h0F, 8'h11, 8'hFF, 4'b1000);

        // XOR stalled by the consumer.
        drive(4'd5, 8'hF0, 8'h3C);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("xor.hold_result", result, 8'hCC);
            check("xor.hold_flags", flags, 4'b1000);
            check("xor.hold_valid", out_valid, 1);
            check("xor.in_ready_low", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1 check("xor.in_ready_high", in_ready, 1);
        tick();
        check("xor.idle", out_valid, 0);

        // Reset three cycles into a DIV.
        drive(4'd11, 8'h2A, 8'h03);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst.out_valid", out_valid, 0);
        check("mid_rst.result", result, 0);
        check("mid_rst.flags", flags, 0);
        check("mid_rst.busy", busy, 0);
        tick();
        tick();
        rst = 1'b1;
        drive(4'd4, 8'h00, 8'h00);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("not.out_valid", out_valid, 1);
        check("not.result", result, 8'hFF);
        check("not.flags", flags, 4'b1000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/leg_alu_mc.md
# leg_alu_mc

Parametrised multi-cycle ALU for the LEG datapath, the successor to the 8-bit combinational ALU. It adds width scaling, shift/rotate operations, an iterative multiply/divide unit, a registered NZCV flag output and a valid/ready handshake on both sides. It sits between the register-file read stage and the write-back stage, and it stalls the issue logic through `in_ready` while an iterative operation runs.

## Interface
- `WIDTH`, 8: operand and result width. Must be a power of two, ≥ 4.
- `clk` input 1: clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operation request valid.
- `in_ready` output 1: block accepts a request this cycle.
- `opcode` input 4: operation select.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `out_valid` output 1: result and flags valid.
- `out_ready` input 1: consumer takes the result.
- `result` output WIDTH: registered result.
- `flags` output 4: registered {N, Z, C, V}, bit 3 = N.
- `busy` output 1: high while in BUSY.

## Operation
- Opcodes:
  - 0 ADD; 1 SUB (a−b); 2 AND; 3 OR; 4 NOT a; 5 XOR.
  - 6 SHL; 7 SHR (logical); 8 ASR; 9 ROL.
  - 10 MUL (low WIDTH bits); 11 DIV (unsigned quotient); 12 MOD (unsigned remainder).
  - 13 reserved (result 0); 14 NOR; 15 NAND.
- Shift amount for opcodes 6–9 = b[$clog2(WIDTH)-1:0]. Upper bits of b are ignored.
- Flags are computed on every accepted op:
  - Z = (result == 0).
  - N = result[WIDTH-1].
  - C: ADD = carry out. SUB = 1 when a ≥ b unsigned. Shifts = last bit shifted out, 0 when amount is 0. ROL = 0. MUL = 1 when the high half of the product ≠ 0. DIV/MOD = 1 on divide-by-zero. All other ops = 0.
  - V: signed overflow for ADD/SUB, 0 for all other ops.
- Divide-by-zero: DIV returns all ones, MOD returns a. The op still takes the full iterative latency.
- FSM:
  - IDLE: on `in_valid & in_ready`, opcodes 10–12 go to BUSY; all others register result/flags and go to DONE.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIV/MOD) step per cycle, using an internal count from WIDTH−1 down to 0. At count 0, register result/flags and go to DONE.
  - DONE: `out_valid` = 1. On `out_ready`: go to IDLE, or accept a new request in the same cycle if one is presented.
- `in_ready` = (state == IDLE) | (state == DONE & out_ready).
- `result` and `flags` are held stable while `out_valid & !out_ready`.
- Operands and opcode are captured on acceptance. Later input changes do not affect the in-flight op.

## Timing
- Reset: state = IDLE; `result` = 0; `flags` = 0; `out_valid` = 0; `busy` = 0; `in_ready` = 1 once `rst` deasserts.
- Single-cycle ops: accepted at edge N, `out_valid` at edge N+1.
- MUL/DIV/MOD: accepted at edge N, `busy` from N+1 to N+WIDTH, `out_valid` at N+WIDTH+1.
- Throughput: one single-cycle op per clock when `out_ready` is held high (back-to-back through DONE).
- Reset mid-operation: the in-flight op is discarded and all outputs return to reset values immediately (asynchronous). No partial result is ever presented.
- `in_valid` while BUSY is ignored; `in_ready` = 0.

## Configuration
- `LEG_ALU_MULDIV_EN` defined: opcodes 10–12 use the iterative BUSY path as above.
- Not defined:
  - The BUSY state and the iterative datapath are removed.
  - Opcodes 10–12 behave as opcode 13: result 0, flags {0,1,0,0}, single-cycle latency.
  - `busy` is tied to 0.

## Test plan
- Reset then ADD, WIDTH=8, a=0x7F, b=0x01 -> result 0x80, flags N=1 Z=0 C=0 V=1, `out_valid` one cycle after acceptance.
- SUB a=0x05, b=0x05, then SHL a=0x81, b=0x09 (shift amount 1) with `out_ready` held high -> 0x00 (Z=1, C=1), then 0x02 (C=1) on consecutive cycles.
- MUL a=0x10, b=0x20 (`LEG_ALU_MULDIV_EN` defined) -> `busy` for 8 cycles, result 0x00, C=1, Z=1, `out_valid` 9 cycles after acceptance.
- DIV a=0x2A, b=0x00 -> result 0xFF, C=1. MOD a=0x2A, b=0x05 -> result 0x02.
- `out_ready` = 0 for 3 cycles after XOR a=0xF0, b=0x3C -> result 0xCC held stable, `in_ready` = 0 until `out_ready` rises.
- Assert `rst` low 3 cycles into a DIV -> `out_valid` = 0 and `result` = 0 immediately. After release, a new NOT a=0x00 returns 0xFF.
